// File: rtl/nibble_frame_collector_pkg.sv
// nibble_frame_collector_pkg: byte field layout and collector state shared with the output loader
package nibble_frame_collector_pkg;
  localparam int MODE_HI = 7;
  localparam int MODE_LO = 5;
  localparam int RDY_BIT = 4;
  localparam int NIB_HI = 3;
  localparam int NIBBLE_W = 4;
  typedef enum logic [0:0] {COL_IDLE, COL_COLLECT} col_state_t;
endpackage

// File: rtl/nibble_frame_collector_if.sv
// nibble_frame_collector_if: nibble stream in, held frame result out
interface nibble_frame_collector_if #(parameter int W = 32);
  localparam int NIB = W / 4;
  localparam int CNT_W = $clog2(2 * NIB + 2);
  logic sample_en;
  logic [7:0] in_byte;
  logic clear;
  logic out_ack;
  logic busy;
  logic out_valid;
  logic [W-1:0] word_a;
  logic [W-1:0] word_b;
  logic [2:0] mode_out;
  logic [CNT_W-1:0] nib_count;
  logic short_frame;
  logic overrun;
  logic mode_err;
  logic dropped;
  modport master (
    output sample_en, in_byte, clear, out_ack,
    input busy, out_valid, word_a, word_b, mode_out, nib_count, short_frame, overrun, mode_err, dropped
  );
  modport slave (
    input sample_en, in_byte, clear, out_ack,
    output busy, out_valid, word_a, word_b, mode_out, nib_count, short_frame, overrun, mode_err, dropped
  );
endinterface

// File: rtl/nibble_frame_result.sv
// nibble_frame_result: holds a committed frame with valid/ack handshake and sticky drop flag
module nibble_frame_result #(
  parameter int W = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             commit,
  input  logic             ack,
  input  logic [W-1:0]     d_a,
  input  logic [W-1:0]     d_b,
  input  logic [2:0]       d_mode,
  input  logic [CNT_W-1:0] d_cnt,
  input  logic             d_mode_err,
  output logic             out_valid,
  output logic [W-1:0]     word_a,
  output logic [W-1:0]     word_b,
  output logic [2:0]       mode_out,
  output logic [CNT_W-1:0] nib_count,
  output logic             short_frame,
  output logic             overrun,
  output logic             mode_err,
  output logic             dropped
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(W / 2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      {out_valid, word_a, word_b, mode_out, nib_count, short_frame, overrun, mode_err, dropped} <= '0;
    else if (clear)
      {out_valid, word_a, word_b, mode_out, nib_count, short_frame, overrun, mode_err, dropped} <= '0;
    else if (commit) begin
      word_a <= d_a;
      word_b <= d_b;
      mode_out <= d_mode;
      nib_count <= d_cnt;
      short_frame <= d_cnt < FULL;
      overrun <= d_cnt > FULL;
      mode_err <= d_mode_err;
      out_valid <= 1'b1;
      dropped <= dropped | (out_valid & ~ack);
    end else if (ack)
      out_valid <= 1'b0;
endmodule

// File: rtl/nibble_frame_collector.sv
// nibble_frame_collector: reassembles MSB-first nibble frames into two words with integrity flags
module nibble_frame_collector
  import nibble_frame_collector_pkg::*;
#(
  parameter int W = 32
) (
  input logic clk,
  input logic rst_n,
  nibble_frame_collector_if.slave bus
);
  localparam int NIB = W / 4;
  localparam int CNT_W = $clog2(2 * NIB + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * NIB + 1);
  col_state_t state;
  logic [W-1:0] acc_a, acc_b;
  logic [2:0] cur_mode, mode;
  logic [CNT_W-1:0] cnt;
  logic mode_err_acc, rdy, commit;
  logic [NIBBLE_W-1:0] nib;
  assign rdy = bus.in_byte[RDY_BIT];
  assign mode = bus.in_byte[MODE_HI:MODE_LO];
  assign nib = bus.in_byte[NIB_HI:0];
  assign commit = bus.sample_en && !bus.clear && state == COL_COLLECT && !rdy;
  assign bus.busy = state == COL_COLLECT;
  // Accumulators are zeroed on commit so unreceived slots of the next frame read 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= COL_IDLE;
      acc_a <= '0;
      acc_b <= '0;
      cur_mode <= '0;
      cnt <= '0;
      mode_err_acc <= 1'b0;
    end else if (bus.clear || commit) begin
      state <= COL_IDLE;
      acc_a <= '0;
      acc_b <= '0;
      cur_mode <= '0;
      cnt <= '0;
      mode_err_acc <= 1'b0;
    end else if (bus.sample_en && rdy) begin
      if (state == COL_IDLE) begin
        acc_a[W-1 -: NIBBLE_W] <= nib;
        cur_mode <= mode;
        cnt <= CNT_W'(1);
        state <= COL_COLLECT;
      end else begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt == CNT_W'(NIB - 1 - i)) acc_a[NIBBLE_W*i +: NIBBLE_W] <= nib;
          if (cnt == CNT_W'(2 * NIB - 1 - i)) acc_b[NIBBLE_W*i +: NIBBLE_W] <= nib;
        end
        cnt <= cnt == CNT_MAX ? cnt : cnt + 1'b1;
        if (mode != cur_mode) mode_err_acc <= 1'b1;
      end
    end
  nibble_frame_result #(.W(W), .CNT_W(CNT_W)) u_result (
    .clk(clk),
    .rst_n(rst_n),
    .clear(bus.clear),
    .commit(commit),
    .ack(bus.out_ack),
    .d_a(acc_a),
    .d_b(acc_b),
    .d_mode(cur_mode),
    .d_cnt(cnt),
    .d_mode_err(mode_err_acc),
    .out_valid(bus.out_valid),
    .word_a(bus.word_a),
    .word_b(bus.word_b),
    .mode_out(bus.mode_out),
    .nib_count(bus.nib_count),
    .short_frame(bus.short_frame),
    .overrun(bus.overrun),
    .mode_err(bus.mode_err),
    .dropped(bus.dropped)
  );
endmodule

// File: tb/tb_nibble_frame_collector.sv
// tb_nibble_frame_collector: directed frames with queued expected results checked by a result monitor
module tb_nibble_frame_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  nibble_frame_collector_if #(.W(32)) bus();
  nibble_frame_collector #(.W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic [4:0]  c;
    logic s, o, me, d;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  logic pv = 1'b0;
  logic pb = 1'b0;
  localparam logic [31:0] A1 = 32'hDEADBEEF;
  localparam logic [31:0] B1 = 32'h12345678;
  localparam logic [31:0] A2 = 32'h01234567;
  localparam logic [31:0] B2 = 32'h89ABCDEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_words"}, {bus.word_a, bus.word_b}, 64'd0);
    chk({tag, "_ctl"}, 64'({bus.busy, bus.out_valid, bus.mode_out, bus.nib_count, bus.short_frame,
                            bus.overrun, bus.mode_err, bus.dropped}), 64'd0);
  endtask

  task automatic step(input logic en, input logic [7:0] b);
    bus.sample_en = en;
    bus.in_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_res();
    bus.out_ack = 1'b1;
    step(1'b0, 8'h00);
    bus.out_ack = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m, input logic [4:0] c,
                      input logic s, input logic o, input logic me, input logic d);
    exp_t x;
    x.a = a; x.b = b; x.m = m; x.c = c; x.s = s; x.o = o; x.me = me; x.d = d;
    q.push_back(x);
  endtask

  // n nibbles of a then b (extras are 0xA), mode becomes 2 from nibble index swi, optional gaps/terminator/ack
  task automatic frame(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b, input int n,
                       input bit gaps, input int swi, input bit term, input bit ackt);
    logic [3:0] nb;
    logic [2:0] mm;
    for (int k = 0; k < n; k++) begin
      nb = k < 8 ? a[(31 - 4*k) -: 4] : k < 16 ? b[(31 - 4*(k-8)) -: 4] : 4'hA;
      mm = k >= swi ? 3'd2 : m;
      step(1'b1, {mm, 1'b1, nb});
      if (gaps) begin
        step(1'b0, 8'h00);
        chk("busy_gap", 64'(bus.busy), 64'd1);
      end
    end
    if (term) begin
      bus.out_ack = ackt;
      step(1'b1, 8'h00);
      bus.out_ack = 1'b0;
    end
  endtask

  // A new result is either out_valid rising or a commit (busy falling) while out_valid is held
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && (!pv || (pb && !bus.busy))) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got word_a=%0h with nothing expected", bus.word_a);
      end else begin
        e = q.pop_front();
        chk("word_a", 64'(bus.word_a), 64'(e.a));
        chk("word_b", 64'(bus.word_b), 64'(e.b));
        chk("mode_out", 64'(bus.mode_out), 64'(e.m));
        chk("nib_count", 64'(bus.nib_count), 64'(e.c));
        chk("flags", 64'({bus.short_frame, bus.overrun, bus.mode_err, bus.dropped}),
            64'({e.s, e.o, e.me, e.d}));
      end
    end
    pv = bus.out_valid;
    pb = bus.busy;
  end

  initial begin
    bus.sample_en = 1'b0;
    bus.in_byte = 8'h00;
    bus.clear = 1'b0;
    bus.out_ack = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    push(A1, B1, 3'd5, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(3'd5, A1, B1, 16, 1'b0, 99, 1'b1, 1'b0);
    chk("latency_valid", 64'(bus.out_valid), 64'd1);
    ack_res();
    chk("ack_clears_valid", 64'(bus.out_valid), 64'd0);
    chk("data_kept", 64'(bus.word_a), 64'(A1));
    push(A1, 32'h12345670, 3'd5, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(3'd5, A1, B1, 15, 1'b0, 99, 1'b1, 1'b0);
    ack_res();
    push(A1, B1, 3'd5, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(3'd5, A1, B1, 16, 1'b1, 99, 1'b1, 1'b0);
    ack_res();
    push(A1, B1, 3'd5, 5'd17, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(3'd5, A1, B1, 18, 1'b0, 8, 1'b1, 1'b0);
    ack_res();
    push(A1, B1, 3'd5, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    push(A2, B2, 3'd3, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(3'd5, A1, B1, 16, 1'b0, 99, 1'b1, 1'b0);
    frame(3'd3, A2, B2, 16, 1'b0, 99, 1'b1, 1'b0);
    chk("dropped_set", 64'(bus.dropped), 64'd1);
    bus.clear = 1'b1;
    step(1'b0, 8'h00);
    bus.clear = 1'b0;
    chk("clear_dropped", 64'({bus.out_valid, bus.dropped}), 64'd0);
    push(A1, B1, 3'd5, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    push(A2, B2, 3'd3, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(3'd5, A1, B1, 16, 1'b0, 99, 1'b1, 1'b0);
    frame(3'd3, A2, B2, 16, 1'b0, 99, 1'b1, 1'b1);
    chk("ack_coincident", 64'({bus.out_valid, bus.dropped}), 64'b10);
    ack_res();
    frame(3'd5, A1, B1, 6, 1'b0, 99, 1'b0, 1'b0);
    chk("busy_mid", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00);
    push(A1, B1, 3'd5, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(3'd5, A1, B1, 16, 1'b0, 99, 1'b1, 1'b0);
    frame(3'd5, A1, B1, 6, 1'b0, 99, 1'b0, 1'b0);
    bus.clear = 1'b1;
    step(1'b1, 8'hB3);
    bus.clear = 1'b0;
    check_zero("clear_mid");
    push(A2, B2, 3'd3, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(3'd3, A2, B2, 16, 1'b0, 99, 1'b1, 1'b0);
    ack_res();
    repeat (3) step(1'b0, 8'h00);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
